// File: rtl/acq_tm_pkg.sv
// Shared types and constants for the acquisition timing manager.
// The optional timeout feature is selected in the top level by ACQ_TIMING_MANAGER_TIMEOUT_EN.
package acq_tm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACQ  = 1'b1
    } acq_state_t;

    localparam int unsigned NUM_CH_DEF  = 8;
    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned RATIO_W_DEF = 16;

    // Wide all-ones pattern; users slice it down to their counter width.
    localparam logic [63:0] TIME_SAT = '1;

endpackage

// File: rtl/event_ratio_divider.sv
// Divides qualified PWM-carrier events by user_ratio+1 into a one-cycle trigger.
module event_ratio_divider
    import acq_tm_pkg::*;
#(
    parameter int unsigned RATIO_W = RATIO_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               event_qualifier,
    input  logic [RATIO_W-1:0] user_ratio,
    output logic               trigger
);

    logic [RATIO_W-1:0] cnt;

    // Count events; on the event that matches the ratio, restart and pulse trigger.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            trigger <= 1'b0;
        end else begin
            trigger <= 1'b0;
            if (event_qualifier) begin
                if (cnt == user_ratio) begin
                    cnt     <= '0;
                    trigger <= 1'b1;
                end else begin
                    cnt <= cnt + RATIO_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/acq_timing_manager.sv
// Acquisition timing manager: ratio-divided trigger, per-channel done timing,
// completion interrupt and sticky overrun flag.
// Optional macro ACQ_TIMING_MANAGER_TIMEOUT_EN adds timeout_cycles/timeout.
module acq_timing_manager
    import acq_tm_pkg::*;
#(
    parameter int unsigned NUM_CH  = NUM_CH_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned RATIO_W = RATIO_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    event_qualifier,
    input  logic [RATIO_W-1:0]      user_ratio,
    input  logic [NUM_CH-1:0]       en_bits,
    input  logic [NUM_CH-1:0]       done,
    input  logic                    clr_flags,
    output logic                    trigger,
    output logic                    busy,
    output logic                    sched_isr,
    output logic [NUM_CH*CNT_W-1:0] ch_time,
    output logic                    overrun
`ifdef ACQ_TIMING_MANAGER_TIMEOUT_EN
    ,
    input  logic [CNT_W-1:0]        timeout_cycles,
    output logic                    timeout
`endif
);

    localparam logic [CNT_W-1:0] SAT = TIME_SAT[CNT_W-1:0];

    acq_state_t        state;
    logic [NUM_CH-1:0] en_q;
    logic [NUM_CH-1:0] seen;
    logic [CNT_W-1:0]  tcnt;
    logic [NUM_CH-1:0] capture;
    logic              all_done;
`ifdef ACQ_TIMING_MANAGER_TIMEOUT_EN
    logic              to_hit;
`endif

    event_ratio_divider #(
        .RATIO_W (RATIO_W)
    ) u_div (
        .clk             (clk),
        .rst             (rst),
        .event_qualifier (event_qualifier),
        .user_ratio      (user_ratio),
        .trigger         (trigger)
    );

    // Channels newly done this cycle, and whether every latched channel is now covered.
    always_comb begin
        capture  = en_q & done & ~seen;
        all_done = &(seen | (done & en_q) | ~en_q);
`ifdef ACQ_TIMING_MANAGER_TIMEOUT_EN
        to_hit   = (timeout_cycles != '0) && (tcnt == timeout_cycles) && !all_done;
`endif
    end

    // Acquisition FSM with registered outputs; flag sets are ordered after clears so sets win.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            en_q      <= '0;
            seen      <= '0;
            tcnt      <= '0;
            busy      <= 1'b0;
            sched_isr <= 1'b0;
            ch_time   <= '0;
            overrun   <= 1'b0;
`ifdef ACQ_TIMING_MANAGER_TIMEOUT_EN
            timeout   <= 1'b0;
`endif
        end else begin
            sched_isr <= 1'b0;
            if (clr_flags) begin
                overrun <= 1'b0;
`ifdef ACQ_TIMING_MANAGER_TIMEOUT_EN
                timeout <= 1'b0;
`endif
            end
            case (state)
                IDLE: begin
                    if (trigger) begin
                        en_q <= en_bits;
                        seen <= '0;
                        tcnt <= '0;
                        if (en_bits == '0) begin
                            sched_isr <= 1'b1;
                        end else begin
                            state <= ACQ;
                            busy  <= 1'b1;
                        end
                    end
                end
                ACQ: begin
                    if (trigger) begin
                        overrun <= 1'b1;
                    end
                    if (tcnt != SAT) begin
                        tcnt <= tcnt + CNT_W'(1);
                    end
                    seen <= seen | capture;
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (capture[i]) begin
                            ch_time[i*CNT_W +: CNT_W] <= tcnt;
                        end
                    end
                    if (all_done) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        sched_isr <= 1'b1;
                    end
`ifdef ACQ_TIMING_MANAGER_TIMEOUT_EN
                    else if (to_hit) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        sched_isr <= 1'b1;
                        timeout   <= 1'b1;
                        // Channels captured on this same cycle keep their real time.
                        for (int unsigned i = 0; i < NUM_CH; i++) begin
                            if (en_q[i] && !seen[i] && !capture[i]) begin
                                ch_time[i*CNT_W +: CNT_W] <= SAT;
                            end
                        end
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acq_timing_manager.sv
// Self-checking bench for acq_timing_manager.
// Define ACQ_TIMING_MANAGER_TIMEOUT_EN to also exercise the timeout feature.
module tb_acq_timing_manager;

    localparam int NCH = 8;
    localparam int CW  = 16;
    localparam int RW  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              event_qualifier;
    logic [RW-1:0]     user_ratio;
    logic [NCH-1:0]    en_bits;
    logic [NCH-1:0]    done;
    logic              clr_flags;
    logic              trigger;
    logic              busy;
    logic              sched_isr;
    logic [NCH*CW-1:0] ch_time;
    logic              overrun;
`ifdef ACQ_TIMING_MANAGER_TIMEOUT_EN
    logic [CW-1:0]     timeout_cycles;
    logic              timeout;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [CW-1:0] exp_ch [NCH];
    logic          ov_model;
    logic          to_model;
    int            tmo;
    int            st [NCH];
    int            ln [NCH];

    always #5 clk = ~clk;

    acq_timing_manager #(
        .NUM_CH  (NCH),
        .CNT_W   (CW),
        .RATIO_W (RW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .event_qualifier (event_qualifier),
        .user_ratio      (user_ratio),
        .en_bits         (en_bits),
        .done            (done),
        .clr_flags       (clr_flags),
        .trigger         (trigger),
        .busy            (busy),
        .sched_isr       (sched_isr),
        .ch_time         (ch_time),
        .overrun         (overrun)
`ifdef ACQ_TIMING_MANAGER_TIMEOUT_EN
        ,
        .timeout_cycles  (timeout_cycles),
        .timeout         (timeout)
`endif
    );

    function automatic logic [CW-1:0] get_ch(input int i);
        return ch_time[i*CW +: CW];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        event_qualifier = 1'b0;
        done = '0;
        clr_flags = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NCH; i++) exp_ch[i] = '0;
        ov_model = 1'b0;
        to_model = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        event_qualifier = 1'b1;
        user_ratio = '0;
        en_bits = '1;
        done = '1;
        clr_flags = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({trigger, busy, sched_isr, overrun} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 0000", {trigger, busy, sched_isr, overrun});
        end
        checks++;
        if (ch_time !== '0) begin
            failures++;
            $display("FAIL reset_ch_time: got %h expected 0", ch_time);
        end
`ifdef ACQ_TIMING_MANAGER_TIMEOUT_EN
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_timeout: got %b expected 0", timeout);
        end
`endif
        event_qualifier = 1'b0;
        done = '0;
        rst = 1'b0;
        for (int i = 0; i < NCH; i++) exp_ch[i] = '0;
        ov_model = 1'b0;
        to_model = 1'b0;
    endtask

    // Event stream with en_bits=0: each trigger must give an interrupt one cycle later and no busy.
    task automatic test_ratio(input int r, input int ncyc, input bit randomized);
        logic exp_trig, exp_isr, ev;
        int   evcount;
        do_reset();
        user_ratio = RW'(r);
        en_bits = '0;
        exp_trig = 1'b0;
        exp_isr = 1'b0;
        evcount = 0;
        for (int j = 0; j < ncyc; j++) begin
            @(negedge clk);
            checks++;
            if (trigger !== exp_trig) begin
                failures++;
                $display("FAIL ratio_trigger r=%0d cyc=%0d: got %b expected %b", r, j, trigger, exp_trig);
            end
            checks++;
            if (sched_isr !== exp_isr || busy !== 1'b0) begin
                failures++;
                $display("FAIL ratio_isr r=%0d cyc=%0d: got isr=%b busy=%b expected isr=%b busy=0",
                         r, j, sched_isr, busy, exp_isr);
            end
            exp_isr = exp_trig;
            ev = randomized ? ($urandom_range(0, 2) == 0) : (j % 10 == 0);
            if (ev) begin
                evcount++;
                exp_trig = (evcount % (r + 1) == 0);
            end else begin
                exp_trig = 1'b0;
            end
            event_qualifier = ev;
        end
        @(negedge clk);
        event_qualifier = 1'b0;
    endtask

    // One acquisition: channel i (if enabled) raises done at ACQ cycle st[i] for ln[i] cycles.
    // inj >= 0 injects an extra event (trigger one cycle later) during the run.
    task automatic run_acq(input logic [NCH-1:0] en, input int inj, input string tag);
        int c, e;
        bit hit;
        user_ratio = '0;
        en_bits = en;
`ifdef ACQ_TIMING_MANAGER_TIMEOUT_EN
        timeout_cycles = CW'(tmo);
`endif
        c = -1;
        for (int i = 0; i < NCH; i++) if (en[i] && st[i] > c) c = st[i];
        e = c;
        hit = 1'b0;
        if (tmo != 0 && c > tmo) begin
            e = tmo;
            hit = 1'b1;
        end
        for (int i = 0; i < NCH; i++) begin
            if (en[i]) exp_ch[i] = (!hit || st[i] <= tmo) ? CW'(st[i]) : '1;
        end
        if (inj >= 0 && inj + 1 <= e) ov_model = 1'b1;
        if (hit) to_model = 1'b1;

        @(negedge clk);
        event_qualifier = 1'b1;
        @(negedge clk);
        event_qualifier = 1'b0;
        checks++;
        if (trigger !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_start: got trigger=%b busy=%b expected 1 0", tag, trigger, busy);
        end
        for (int k = 0; k <= e + 3; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== (k <= e) || sched_isr !== (k == e + 1) ||
                trigger !== (inj >= 0 && k == inj + 1)) begin
                failures++;
                $display("FAIL %s_cycle%0d: got busy=%b isr=%b trig=%b expected %b %b %b", tag, k,
                         busy, sched_isr, trigger, (k <= e), (k == e + 1), (inj >= 0 && k == inj + 1));
            end
            event_qualifier = (k == inj);
            if (k >= 1) en_bits = NCH'($urandom);
            for (int i = 0; i < NCH; i++) begin
                if (en[i]) done[i] = (k >= st[i] && k < st[i] + ln[i]);
                else       done[i] = 1'($urandom);
            end
        end
        done = '0;
        event_qualifier = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NCH; i++) begin
            checks++;
            if (get_ch(i) !== exp_ch[i]) begin
                failures++;
                $display("FAIL %s_ch_time[%0d]: got %0d expected %0d", tag, i, get_ch(i), exp_ch[i]);
            end
        end
        checks++;
        if (overrun !== ov_model) begin
            failures++;
            $display("FAIL %s_overrun: got %b expected %b", tag, overrun, ov_model);
        end
`ifdef ACQ_TIMING_MANAGER_TIMEOUT_EN
        checks++;
        if (timeout !== to_model) begin
            failures++;
            $display("FAIL %s_timeout: got %b expected %b", tag, timeout, to_model);
        end
`endif
    endtask

    task automatic test_channel_timing();
        do_reset();
        for (int i = 0; i < NCH; i++) begin st[i] = 0; ln[i] = 1; end
        st[0] = 7;
        st[2] = 20;
        run_acq(8'h05, -1, "timing");
    endtask

    task automatic test_empty_enable();
        do_reset();
        for (int i = 0; i < NCH; i++) begin st[i] = 0; ln[i] = 1; end
        test_ratio(0, 12, 1'b0);
    endtask

    task automatic test_held_done();
        for (int i = 0; i < NCH; i++) begin st[i] = 0; ln[i] = 1; end
        st[1] = 4;
        ln[1] = 30;
        st[2] = 25;
        run_acq(8'h06, -1, "held");
    endtask

    task automatic test_overrun_clear();
        for (int i = 0; i < NCH; i++) begin st[i] = 0; ln[i] = 1; end
        st[5] = 15;
        run_acq(8'h20, 4, "overrun");
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        ov_model = 1'b0;
        to_model = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL clr_overrun: got %b expected 0", overrun);
        end
    endtask

    task automatic test_random_acq();
        int c, inj;
        logic [NCH-1:0] en;
        for (int n = 0; n < 20; n++) begin
            en = NCH'($urandom_range(1, 255));
            c = 0;
            for (int i = 0; i < NCH; i++) begin
                st[i] = $urandom_range(0, 40);
                ln[i] = $urandom_range(1, 10);
                if (en[i] && st[i] > c) c = st[i];
            end
            inj = (c >= 2 && $urandom_range(0, 1) == 1) ? $urandom_range(0, c - 1) : -1;
            run_acq(en, inj, "rand");
        end
    endtask

    task automatic test_reset_mid_acq();
        do_reset();
        user_ratio = '0;
        en_bits = '1;
        @(negedge clk);
        event_qualifier = 1'b1;
        @(negedge clk);
        event_qualifier = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            done = (k == 2) ? 8'h01 : 8'h00;
        end
        checks++;
        if (busy !== 1'b1 || get_ch(0) !== 16'd2) begin
            failures++;
            $display("FAIL mid_pre_reset: got busy=%b ch0=%0d expected 1 2", busy, get_ch(0));
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sched_isr !== 1'b0 || overrun !== 1'b0 || ch_time !== '0) begin
            failures++;
            $display("FAIL mid_reset: got busy=%b isr=%b ov=%b ch_time=%h expected all 0",
                     busy, sched_isr, overrun, ch_time);
        end
        rst = 1'b0;
        done = '0;
        for (int i = 0; i < NCH; i++) exp_ch[i] = '0;
        ov_model = 1'b0;
        to_model = 1'b0;
    endtask

`ifdef ACQ_TIMING_MANAGER_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        tmo = 50;
        for (int i = 0; i < NCH; i++) begin st[i] = 0; ln[i] = 1; end
        st[0] = 10;
        st[3] = 1000;
        run_acq(8'h09, -1, "timeout");
        for (int n = 0; n < 6; n++) begin
            tmo = $urandom_range(5, 30);
            for (int i = 0; i < NCH; i++) begin
                st[i] = $urandom_range(0, 40);
                ln[i] = $urandom_range(1, 5);
            end
            run_acq(NCH'($urandom_range(1, 255)), -1, "rand_timeout");
        end
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL clr_timeout: got %b expected 0", timeout);
        end
        tmo = 0;
        timeout_cycles = '0;
        ov_model = 1'b0;
        to_model = 1'b0;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tmo = 0;
`ifdef ACQ_TIMING_MANAGER_TIMEOUT_EN
        timeout_cycles = '0;
`endif
        test_reset();
        test_ratio(3, 130, 1'b0);
        test_ratio(0, 40, 1'b1);
        test_ratio(int'($urandom_range(1, 5)), 120, 1'b1);
        test_empty_enable();
        test_channel_timing();
        test_held_done();
        test_overrun_clear();
        test_random_acq();
        test_reset_mid_acq();
`ifdef ACQ_TIMING_MANAGER_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
